sop_tt_engine: RTL and testbench

Programmable N-input Boolean function unit, generalising the fixed 4-input sum-of-products gate to a run-time-loadable truth table. Results are registered behind a valid/ready output stage. An exhaustive sweep mode walks all 2^N_IN input combinations, streams every result and counts the ones, so the unit can self-characterise its loaded function. It sits between a stimulus source and a checker/logger in the logic-lab datapath.

---
 rtl/sop_tt_pkg.sv | 13 +
 rtl/sop_tt_engine_if.sv | 30 +++
 rtl/sop_tt_engine_tt_mux.sv | 13 +
 rtl/sop_tt_engine.sv | 122 ++++++++++++
 tb/tb_sop_tt_engine.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/sop_tt_pkg.sv
// Shared types and constants for the programmable truth-table engine.
package sop_tt_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } state_e;

    // Table loaded at reset for the 4-input configuration.
    localparam logic [15:0] DEF_TT = 16'hFF0D;

endpackage

// File: rtl/sop_tt_engine_if.sv
// Request/result bundle between stimulus source, sop_tt_engine and checker.
interface sop_tt_engine_if #(parameter int N_IN = 4);

    localparam int TT_W = 2**N_IN;

    logic              tt_load;
    logic [TT_W-1:0]   tt_data;
    logic              in_valid;
    logic [N_IN-1:0]   in_vec;
    logic              in_ready;
    logic              sweep_start;
    logic              sweep_busy;
    logic              sweep_done;
    logic [N_IN:0]     ones_cnt;
    logic              out_valid;
    logic              out_ready;
    logic [N_IN-1:0]   out_vec;
    logic              out_f;

    modport master (
        output tt_load, tt_data, in_valid, in_vec, sweep_start, out_ready,
        input  in_ready, sweep_busy, sweep_done, ones_cnt, out_valid, out_vec, out_f
    );

    modport slave (
        input  tt_load, tt_data, in_valid, in_vec, sweep_start, out_ready,
        output in_ready, sweep_busy, sweep_done, ones_cnt, out_valid, out_vec, out_f
    );

endinterface

// File: rtl/sop_tt_engine_tt_mux.sv
// Combinational truth-table selector: returns table bit at the given index.
module tt_mux #(
    parameter  int N_IN = 4,
    localparam int TT_W = 2**N_IN
) (
    input  logic [TT_W-1:0] tt_i,
    input  logic [N_IN-1:0] idx_i,
    output logic            f_o
);

    assign f_o = tt_i[idx_i];

endmodule

// File: rtl/sop_tt_engine.sv
// Run-time programmable N-input Boolean function with registered valid/ready
// output and an exhaustive self-characterisation sweep.
module sop_tt_engine
    import sop_tt_pkg::*;
#(
    parameter  int              N_IN   = 4,
    localparam int              TT_W   = 2**N_IN,
    parameter  logic [TT_W-1:0] DEF_TT = TT_W'(sop_tt_pkg::DEF_TT)
) (
    input  logic             clk,
    input  logic             rst_n,
    sop_tt_engine_if.slave   bus
);

    localparam logic [N_IN-1:0] LAST_VEC = {N_IN{1'b1}};

    state_e            state_q, state_d;
    logic [N_IN:0]     idx_q, idx_d;
    logic [TT_W-1:0]   tt_q, tt_d;
    logic              out_valid_q, out_valid_d;
    logic [N_IN-1:0]   out_vec_q, out_vec_d;
    logic              out_f_q, out_f_d;
    logic              out_swp_q, out_swp_d;
    logic [N_IN:0]     ones_q, ones_d;

    logic              free;
    logic              in_ready;
    logic              eval;
    logic              sweep_go;
    logic              sweep_acc;
    logic [N_IN-1:0]   sel;
    logic              f;

    assign free      = ~out_valid_q | bus.out_ready;
    assign in_ready  = rst_n & (state_q == IDLE) & free;
    assign eval      = bus.in_valid & in_ready;
    // idx MSB set means every vector has been issued; wait for the tail to drain.
    assign sweep_go  = (state_q == SWEEP) & free & ~idx_q[N_IN];
    // Only sweep-tagged beats count, so a single beat captured alongside
    // sweep_start never pollutes ones_cnt.
    assign sweep_acc = out_valid_q & bus.out_ready & out_swp_q;
    assign sel       = (state_q == SWEEP) ? idx_q[N_IN-1:0] : bus.in_vec;

    tt_mux #(.N_IN(N_IN)) u_tt_mux (
        .tt_i  (tt_q),
        .idx_i (sel),
        .f_o   (f)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        tt_d        = tt_q;
        out_valid_d = out_valid_q;
        out_vec_d   = out_vec_q;
        out_f_d     = out_f_q;
        out_swp_d   = out_swp_q;
        ones_d      = ones_q;

        if (sweep_acc) ones_d = ones_q + (N_IN+1)'(out_f_q);

        case (state_q)
            IDLE: begin
                if (bus.tt_load) tt_d = bus.tt_data;
                if (bus.sweep_start) begin
                    state_d = SWEEP;
                    idx_d   = '0;
                    ones_d  = '0;
                end
            end
            SWEEP: if (sweep_acc && out_vec_q == LAST_VEC) state_d = DONE;
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (eval) begin
            out_valid_d = 1'b1;
            out_vec_d   = bus.in_vec;
            out_f_d     = f;
            out_swp_d   = 1'b0;
        end else if (sweep_go) begin
            out_valid_d = 1'b1;
            out_vec_d   = idx_q[N_IN-1:0];
            out_f_d     = f;
            out_swp_d   = 1'b1;
            idx_d       = idx_q + 1'b1;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            tt_q        <= DEF_TT;
            out_valid_q <= 1'b0;
            out_vec_q   <= '0;
            out_f_q     <= 1'b0;
            out_swp_q   <= 1'b0;
            ones_q      <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            tt_q        <= tt_d;
            out_valid_q <= out_valid_d;
            out_vec_q   <= out_vec_d;
            out_f_q     <= out_f_d;
            out_swp_q   <= out_swp_d;
            ones_q      <= ones_d;
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.sweep_busy = (state_q == SWEEP);
    assign bus.sweep_done = (state_q == DONE);
    assign bus.ones_cnt   = ones_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_vec    = out_vec_q;
    assign bus.out_f      = out_f_q;

endmodule

// File: tb/tb_sop_tt_engine.sv
// Directed bench for sop_tt_engine: single evaluations, sweeps, stalls,
// reset abort, and a 2-input XOR instance.
module tb_sop_tt_engine;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    sop_tt_engine_if #(.N_IN(4)) b4 ();
    sop_tt_engine_if #(.N_IN(2)) b2 ();

    sop_tt_engine #(.N_IN(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b4.slave)
    );

    sop_tt_engine #(.N_IN(2), .DEF_TT(4'b0110)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b2.slave)
    );

    int          n_chk  = 0;
    int          n_pass = 0;
    logic [15:0] exp_tt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_tt(input logic [15:0] t);
        b4.tt_data = t;
        b4.tt_load = 1'b1;
        step();
        b4.tt_load = 1'b0;
        exp_tt     = t;
    endtask

    // Run a 16-beat sweep; optionally stall stall_len cycles on beat stall_beat
    // while trying (and failing) to load an all-zero table.
    task automatic sweep4(input int exp_ones, input int stall_beat, input int stall_len);
        int n, nb, rem;
        b4.out_ready   = 1'b1;
        b4.sweep_start = 1'b1;
        step();
        b4.sweep_start = 1'b0;
        chk("busy", b4.sweep_busy, 1);
        n = 0; nb = 0; rem = stall_len;
        while (!b4.sweep_done && n < 200) begin
            if (b4.out_valid && b4.out_vec == stall_beat[3:0] && rem > 0) begin
                b4.out_ready = 1'b0;
                b4.tt_load   = 1'b1;
                b4.tt_data   = 16'h0000;
                if (rem < stall_len) begin
                    chk("hold_vec", b4.out_vec, stall_beat);
                    chk("hold_f", b4.out_f, exp_tt[stall_beat]);
                end
                rem--;
            end else begin
                b4.out_ready = 1'b1;
                b4.tt_load   = 1'b0;
                if (b4.out_valid) begin
                    chk("beat_vec", b4.out_vec, nb);
                    chk("beat_f", b4.out_f, (nb < 16) ? exp_tt[nb] : 1'bx);
                    nb++;
                end
            end
            step();
            n++;
        end
        b4.tt_load = 1'b0;
        chk("beats", nb, 16);
        chk("done_lat", n, 17 + stall_len);
        chk("ones", b4.ones_cnt, exp_ones);
        step();
        chk("done_pulse", b4.sweep_done, 0);
        chk("ones_hold", b4.ones_cnt, exp_ones);
        chk("idle_busy", b4.sweep_busy, 0);
    endtask

    task automatic sweep2(input int exp_ones, input logic [3:0] tt2);
        int n, nb;
        b2.out_ready   = 1'b1;
        b2.sweep_start = 1'b1;
        step();
        b2.sweep_start = 1'b0;
        n = 0; nb = 0;
        while (!b2.sweep_done && n < 50) begin
            if (b2.out_valid) begin
                chk("x_vec", b2.out_vec, nb);
                chk("x_f", b2.out_f, (nb < 4) ? tt2[nb] : 1'bx);
                nb++;
            end
            step();
            n++;
        end
        chk("x_beats", nb, 4);
        chk("x_done_lat", n, 5);
        chk("x_ones", b2.ones_cnt, exp_ones);
        step();
    endtask

    logic [3:0] sv [5] = '{4'd0, 4'd1, 4'd2, 4'd4, 4'd8};
    logic       se [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    initial begin
        int  n;
        logic seen;
        rst_n = 1'b0;
        b4.tt_load = 1'b0; b4.tt_data = '0; b4.in_valid = 1'b0; b4.in_vec = '0;
        b4.sweep_start = 1'b0; b4.out_ready = 1'b1;
        b2.tt_load = 1'b0; b2.tt_data = '0; b2.in_valid = 1'b0; b2.in_vec = '0;
        b2.sweep_start = 1'b0; b2.out_ready = 1'b1;
        exp_tt = 16'hFF0D;

        step(); step();
        chk("rst_in_ready", b4.in_ready, 0);
        chk("rst_out_valid", b4.out_valid, 0);
        chk("rst_out_vec", b4.out_vec, 0);
        chk("rst_out_f", b4.out_f, 0);
        chk("rst_busy", b4.sweep_busy, 0);
        chk("rst_done", b4.sweep_done, 0);
        chk("rst_ones", b4.ones_cnt, 0);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 5; i++) begin
            b4.in_vec   = sv[i];
            b4.in_valid = 1'b1;
            chk("in_ready", b4.in_ready, 1);
            step();
            b4.in_valid = 1'b0;
            chk("eval_valid", b4.out_valid, 1);
            chk("eval_vec", b4.out_vec, sv[i]);
            chk("eval_f", b4.out_f, se[i]);
            step();
            chk("eval_drain", b4.out_valid, 0);
        end

        sweep4(11, 0, 0);
        sweep4(11, 5, 3);
        load_tt(16'h8000);
        sweep4(1, 0, 0);
        load_tt(16'hFFFF);
        sweep4(16, 0, 0);

        b4.out_ready   = 1'b1;
        b4.sweep_start = 1'b1;
        step();
        b4.sweep_start = 1'b0;
        n = 0;
        while (!(b4.out_valid && b4.out_vec == 4'd7) && n < 50) begin
            step();
            n++;
        end
        chk("reach7", b4.out_vec, 7);
        rst_n = 1'b0;
        step();
        chk("abort_valid", b4.out_valid, 0);
        chk("abort_vec", b4.out_vec, 0);
        chk("abort_f", b4.out_f, 0);
        chk("abort_busy", b4.sweep_busy, 0);
        chk("abort_done", b4.sweep_done, 0);
        chk("abort_ones", b4.ones_cnt, 0);
        chk("abort_in_ready", b4.in_ready, 0);
        rst_n  = 1'b1;
        exp_tt = 16'hFF0D;
        seen   = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (b4.sweep_done || b4.out_valid) seen = 1'b1;
        end
        chk("abort_quiet", seen, 0);
        sweep4(11, 0, 0);

        sweep2(2, 4'b0110);
        b2.tt_data = 4'hF;
        b2.tt_load = 1'b1;
        step();
        b2.tt_load = 1'b0;
        sweep2(4, 4'hF);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
